// File: rtl/mem_stage_ls.sv
// MIPS memory stage: data memory with byte/half/word loads and stores,
// sign/zero extension, alignment checking, optional wait states with a
// stall toward EX, and store-data forwarding from MEM/WB.
//
// state  | meaning
// S_IDLE | ready for a new instruction; single-cycle ops complete here
// S_BUSY | aligned memory access is waiting out its wait states; EX stalled
module mem_stage_ls #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_store_reg,
  input  logic [4:0]  ex_write_reg,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic        wb_misalign
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] st_data_q, st_data_d;

  logic        wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, wb_misalign_q;
  logic [4:0]  wb_write_reg_q;
  logic [31:0] wb_alu_result_q, wb_load_data_q;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              is_store, is_load, mem_op, misalign;
  logic              fwd_hit, complete;
  logic [31:0]       fwd_data, store_src, wdata, rd_word, rd_shift, load_ext;
  logic [15:0]       rd_half;
  logic [3:0]        be;

  assign word_idx = ex_alu_result[ADDR_W+1:2];
  assign byte_off = ex_alu_result[1:0];
  // Both read and write set means store; no read-after-write in one access.
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_read & ~ex_mem_write;
  assign mem_op   = is_store | is_load;
  assign misalign = mem_op & (((ex_size == 2'b01) & byte_off[0]) |
                              (ex_size[1] & (byte_off != 2'b00)));

  assign in_ready = (state_q == S_IDLE);

  // Store-data forwarding from the instruction sitting in MEM/WB
  always_comb begin
    fwd_hit  = wb_valid_q & wb_reg_write_q & (wb_write_reg_q == ex_store_reg) &
               (wb_write_reg_q != 5'd0);
    fwd_data = ex_store_data;
    if (fwd_hit) fwd_data = wb_mem_to_reg_q ? wb_load_data_q : wb_alu_result_q;
  end

  // MEM/WB is a bubble during BUSY, so the decision taken at acceptance is latched
  assign store_src = (state_q == S_BUSY) ? st_data_q : fwd_data;

  // Lane placement and byte enables for stores
  always_comb begin
    wdata = store_src;
    be    = 4'hF;
    case (ex_size)
      2'b00: begin
        wdata = {4{store_src[7:0]}};
        be    = 4'b0001 << byte_off;
      end
      2'b01: begin
        wdata = {2{store_src[15:0]}};
        be    = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {byte_off, 3'b000};
    rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (ex_size)
      2'b00:   load_ext = {{24{~ex_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{~ex_unsigned & rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // Next-state logic: acceptance, wait-state countdown, completion
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_data_d = st_data_q;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (HAS_WAIT && mem_op && !misalign) begin
            state_d   = S_BUSY;
            cnt_d     = WS_LOAD;
            st_data_d = fwd_data;
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, wait counter and latched store data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      st_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_data_q <= st_data_d;
    end
  end

  // MEM/WB register: load on completion, bubble otherwise, frozen while BUSY
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_misalign_q   <= 1'b0;
      wb_write_reg_q  <= 5'd0;
      wb_alu_result_q <= 32'd0;
      wb_load_data_q  <= 32'd0;
    end else if (complete) begin
      wb_valid_q      <= 1'b1;
      wb_reg_write_q  <= ex_reg_write & ~misalign;
      wb_mem_to_reg_q <= ex_mem_to_reg;
      wb_misalign_q   <= misalign;
      wb_write_reg_q  <= ex_write_reg;
      wb_alu_result_q <= ex_alu_result;
      wb_load_data_q  <= (is_load && !misalign) ? load_ext : 32'd0;
    end else if (state_q == S_IDLE) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
    end
  end

  // Data memory write on the completing edge; reset aborts a pending store
  always_ff @(posedge clk) begin
    if (!reset && complete && is_store && !misalign) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[word_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_load_data  = wb_load_data_q;
  assign wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: two instances (no wait states / two wait states),
// a transaction-level model with its own byte-addressed memory, a per-cycle
// compare process, and literal expectations on the directed vectors.
module tb_mem_stage_ls;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  sreg;
    logic [4:0]  wreg;
  } req_t;

  typedef struct {
    int          d;
    int          c;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] ld;
  } exp_t;

  req_t        rq [2];
  logic [1:0]  rst, rdy, wv, wrw, wm2r, wmis;
  logic [4:0]  wreg [2];
  logic [31:0] walu [2];
  logic [31:0] wld  [2];

  mem_stage_ls #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .in_valid(rq[0].valid), .in_ready(rdy[0]),
    .ex_reg_write(rq[0].rw), .ex_mem_to_reg(rq[0].m2r), .ex_mem_read(rq[0].mr),
    .ex_mem_write(rq[0].mw), .ex_size(rq[0].size), .ex_unsigned(rq[0].uns),
    .ex_alu_result(rq[0].addr), .ex_store_data(rq[0].sdata),
    .ex_store_reg(rq[0].sreg), .ex_write_reg(rq[0].wreg),
    .wb_valid(wv[0]), .wb_reg_write(wrw[0]), .wb_mem_to_reg(wm2r[0]),
    .wb_write_reg(wreg[0]), .wb_alu_result(walu[0]), .wb_load_data(wld[0]),
    .wb_misalign(wmis[0]));

  mem_stage_ls #(.ADDR_W(10), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .reset(rst[1]), .in_valid(rq[1].valid), .in_ready(rdy[1]),
    .ex_reg_write(rq[1].rw), .ex_mem_to_reg(rq[1].m2r), .ex_mem_read(rq[1].mr),
    .ex_mem_write(rq[1].mw), .ex_size(rq[1].size), .ex_unsigned(rq[1].uns),
    .ex_alu_result(rq[1].addr), .ex_store_data(rq[1].sdata),
    .ex_store_reg(rq[1].sreg), .ex_write_reg(rq[1].wreg),
    .wb_valid(wv[1]), .wb_reg_write(wrw[1]), .wb_mem_to_reg(wm2r[1]),
    .wb_write_reg(wreg[1]), .wb_alu_result(walu[1]), .wb_load_data(wld[1]),
    .wb_misalign(wmis[1]));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [31:0] mm [2][1024];
  exp_t        expq [$];
  int          bz_d = -1, bz_from = 0, bz_to = 0;
  int          pv_d = -1, pv_c = -100;
  logic        pv_rw;
  logic [4:0]  pv_dst;
  logic [31:0] pv_val;
  bit          chk_en [2];

  function automatic int ws(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic rw, input logic m2r, input logic mr,
                              input logic mw, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [4:0] sreg, input logic [4:0] dst);
    req_t r;
    r.valid = 1'b0; r.rw = rw; r.m2r = m2r; r.mr = mr; r.mw = mw;
    r.size = sz; r.uns = uns; r.addr = a; r.sdata = sd; r.sreg = sreg; r.wreg = dst;
    return r;
  endfunction

  function automatic req_t ld(input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [4:0] dst);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, sz, uns, a, 32'h0, 5'd0, dst);
  endfunction

  function automatic req_t st(input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] sd, input logic [4:0] sreg);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, a, sd, sreg, 5'd0);
  endfunction

  function automatic req_t alu(input logic [4:0] dst, input logic [31:0] v);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, v, 32'h0, 5'd0, dst);
  endfunction

  // Present one instruction at a negedge; the model computes its result,
  // latency and memory effect from byte-level rules.
  task automatic present(input int d, input req_t r, output int lat);
    int a, idx, n, base;
    logic mis, st_op, ld_op, mop;
    logic [31:0] sd, w, v;
    exp_t e;
    st_op = r.mw;
    ld_op = r.mr && !r.mw;
    mop   = st_op || ld_op;
    a     = cyc + 1;
    idx   = int'(r.addr[11:2]);
    base  = int'(r.addr[1:0]);
    n     = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
    mis   = mop && ((base % n) != 0);
    lat   = (mop && !mis) ? ws(d) + 1 : 1;
    sd    = r.sdata;
    if (pv_d == d && pv_c == a - 1 && pv_rw && pv_dst != 5'd0 && pv_dst == r.sreg)
      sd = pv_val;
    v = 32'h0;
    if (st_op && !mis)
      for (int i = 0; i < n; i++) mm[d][idx][8*(base+i) +: 8] = sd[8*i +: 8];
    if (ld_op && !mis) begin
      w = mm[d][idx];
      v = w >> (8 * base);
      if (n == 1)      v = (r.uns || !v[7])  ? (v & 32'h000000FF) : (v | 32'hFFFFFF00);
      else if (n == 2) v = (r.uns || !v[15]) ? (v & 32'h0000FFFF) : (v | 32'hFFFF0000);
    end
    e.d = d; e.c = a + lat - 1; e.rw = r.rw && !mis; e.m2r = r.m2r; e.mis = mis;
    e.wreg = r.wreg; e.alu = r.addr; e.ld = v;
    expq.push_back(e);
    bz_d = d; bz_from = a; bz_to = a + lat - 1;
    pv_d = d; pv_c = e.c; pv_rw = e.rw; pv_dst = r.wreg;
    pv_val = r.m2r ? v : r.addr;
    rq[d] = r;
    rq[d].valid = 1'b1;
  endtask

  task automatic issue(input int d, input req_t r);
    int lat;
    present(d, r, lat);
    repeat (lat) @(posedge clk);
    @(negedge clk);
    rq[d].valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en[d]) begin
        bit exp_v, exp_r;
        exp_v = (expq.size() > 0) && (expq[0].d == d) && (expq[0].c == cyc);
        exp_r = !(bz_d == d && cyc >= bz_from && cyc < bz_to);
        chk($sformatf("d%0d in_ready", d), 32'(rdy[d]), 32'(exp_r));
        chk($sformatf("d%0d wb_valid", d), 32'(wv[d]), 32'(exp_v));
        if (exp_v) begin
          chk($sformatf("d%0d wb_reg_write", d), 32'(wrw[d]), 32'(expq[0].rw));
          chk($sformatf("d%0d wb_mem_to_reg", d), 32'(wm2r[d]), 32'(expq[0].m2r));
          chk($sformatf("d%0d wb_misalign", d), 32'(wmis[d]), 32'(expq[0].mis));
          chk($sformatf("d%0d wb_write_reg", d), 32'(wreg[d]), 32'(expq[0].wreg));
          chk($sformatf("d%0d wb_alu_result", d), walu[d], expq[0].alu);
          chk($sformatf("d%0d wb_load_data", d), wld[d], expq[0].ld);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s d%0d in_ready", tag, d), 32'(rdy[d]), 32'h1);
    chk($sformatf("%s d%0d wb_valid", tag, d), 32'(wv[d]), 32'h0);
    chk($sformatf("%s d%0d wb_reg_write", tag, d), 32'(wrw[d]), 32'h0);
    chk($sformatf("%s d%0d wb_mem_to_reg", tag, d), 32'(wm2r[d]), 32'h0);
    chk($sformatf("%s d%0d wb_misalign", tag, d), 32'(wmis[d]), 32'h0);
    chk($sformatf("%s d%0d wb_write_reg", tag, d), 32'(wreg[d]), 32'h0);
    chk($sformatf("%s d%0d wb_alu_result", tag, d), walu[d], 32'h0);
    chk($sformatf("%s d%0d wb_load_data", tag, d), wld[d], 32'h0);
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int lat;
    rst = 2'b11;
    rq[0] = '0;
    rq[1] = '0;
    chk_en[0] = 0;
    chk_en[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    chk_en[0] = 1;
    chk_en[1] = 1;

    // ---------------- no wait states ----------------
    issue(0, st(2'd2, 32'h10, 32'h01010101, 5'd0));
    issue(0, ld(2'd2, 1'b0, 32'h10, 5'd3));
    chk("lw word", wld[0], 32'h01010101);

    issue(0, st(2'd2, 32'h20, 32'h0, 5'd0));
    issue(0, st(2'd0, 32'h23, 32'h80, 5'd0));
    issue(0, ld(2'd0, 1'b1, 32'h23, 5'd4));
    chk("lbu 0x23", wld[0], 32'h00000080);
    issue(0, ld(2'd0, 1'b0, 32'h23, 5'd4));
    chk("lb 0x23", wld[0], 32'hFFFFFF80);
    issue(0, ld(2'd2, 1'b0, 32'h20, 5'd4));
    chk("lw 0x20 after sb", wld[0], 32'h80000000);

    issue(0, st(2'd2, 32'h40, 32'h0, 5'd0));
    issue(0, st(2'd1, 32'h42, 32'hBEEF, 5'd0));
    issue(0, ld(2'd1, 1'b0, 32'h42, 5'd5));
    chk("lh 0x42", wld[0], 32'hFFFFBEEF);
    issue(0, ld(2'd1, 1'b1, 32'h42, 5'd5));
    chk("lhu 0x42", wld[0], 32'h0000BEEF);

    issue(0, ld(2'd1, 1'b0, 32'h41, 5'd6));
    chk("lh 0x41 misalign", 32'(wmis[0]), 32'h1);
    chk("lh 0x41 reg_write", 32'(wrw[0]), 32'h0);
    issue(0, st(2'd1, 32'h41, 32'h1234, 5'd0));
    issue(0, ld(2'd2, 1'b0, 32'h42, 5'd6));
    chk("lw 0x42 misalign", 32'(wmis[0]), 32'h1);
    issue(0, ld(2'd2, 1'b0, 32'h40, 5'd6));
    chk("word 0x40 unchanged", wld[0], 32'hBEEF0000);

    // forwarding from a load, from r0 (blocked), from an ALU op, and across a gap
    issue(0, st(2'd2, 32'h10, 32'h1234, 5'd0));
    issue(0, ld(2'd2, 1'b0, 32'h10, 5'd24));
    issue(0, st(2'd2, 32'h30, 32'h0, 5'd24));
    issue(0, ld(2'd2, 1'b0, 32'h30, 5'd7));
    chk("fwd load r24", wld[0], 32'h00001234);
    issue(0, ld(2'd2, 1'b0, 32'h10, 5'd0));
    issue(0, st(2'd2, 32'h34, 32'hDEAD, 5'd0));
    issue(0, ld(2'd2, 1'b0, 32'h34, 5'd7));
    chk("no fwd r0", wld[0], 32'h0000DEAD);
    issue(0, alu(5'd5, 32'h5555));
    issue(0, st(2'd2, 32'h38, 32'h0, 5'd5));
    issue(0, ld(2'd2, 1'b0, 32'h38, 5'd7));
    chk("fwd alu r5", wld[0], 32'h00005555);
    issue(0, alu(5'd9, 32'h9999));
    idle(1);
    issue(0, st(2'd2, 32'h3C, 32'h7, 5'd9));
    issue(0, ld(2'd2, 1'b0, 32'h3C, 5'd7));
    chk("no fwd after gap", wld[0], 32'h00000007);

    // read+write together is a store; address upper bits wrap
    issue(0, mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'hA5A5A5A5, 5'd0, 5'd0));
    chk("rd+wr no load data", wld[0], 32'h0);
    issue(0, ld(2'd2, 1'b0, 32'h44, 5'd8));
    chk("rd+wr stored", wld[0], 32'hA5A5A5A5);
    issue(0, ld(2'd2, 1'b0, 32'h00001010, 5'd8));
    chk("address wrap", wld[0], 32'h00001234);

    issue(0, alu(5'd1, 32'h11));
    issue(0, alu(5'd2, 32'h22));
    issue(0, alu(5'd3, 32'h33));
    chk("alu b2b", walu[0], 32'h33);
    idle(1);

    // ---------------- two wait states ----------------
    issue(1, st(2'd2, 32'h10, 32'hAABBCCDD, 5'd0));
    present(1, ld(2'd2, 1'b0, 32'h10, 5'd24), lat);
    @(posedge clk); @(negedge clk);
    chk("ws busy1 in_ready", 32'(rdy[1]), 32'h0);
    chk("ws busy1 wb_valid", 32'(wv[1]), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("ws busy2 in_ready", 32'(rdy[1]), 32'h0);
    chk("ws busy2 wb_valid", 32'(wv[1]), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("ws done in_ready", 32'(rdy[1]), 32'h1);
    chk("ws done wb_valid", 32'(wv[1]), 32'h1);
    chk("ws lw data", wld[1], 32'hAABBCCDD);
    rq[1].valid = 1'b0;
    issue(1, st(2'd2, 32'h30, 32'h0, 5'd24));
    issue(1, ld(2'd2, 1'b0, 32'h30, 5'd7));
    chk("ws fwd latched", wld[1], 32'hAABBCCDD);
    issue(1, alu(5'd4, 32'h4444));
    chk("ws alu after load", walu[1], 32'h4444);
    issue(1, ld(2'd1, 1'b0, 32'h41, 5'd6));
    chk("ws misalign", 32'(wmis[1]), 32'h1);

    // reset during the second busy cycle aborts the store
    issue(1, st(2'd2, 32'h50, 32'h11111111, 5'd0));
    idle(1);
    chk_en[1] = 0;
    rq[1] = st(2'd2, 32'h50, 32'hCAFEF00D, 5'd0);
    rq[1].valid = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b1;
    rq[1].valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b0;
    chk_zero(1, "abort");
    bz_d = -1;
    pv_d = -1;
    chk_en[1] = 1;
    issue(1, ld(2'd2, 1'b0, 32'h50, 5'd7));
    chk("abort word unchanged", wld[1], 32'h11111111);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
